// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared widths, FSM states and parity helper for mult_rr_arbiter
package mult_arb_pkg;

   localparam int DATA_W = 16;
   localparam int RES_W  = 32;

   typedef enum logic [2:0] {
      IDLE,
      SEND_A,
      GAP,
      SEND_B,
      WAIT,
      RESP
   } state_e;

   // Even parity of a word; 16-bit operands are zero-extended by the caller
   function automatic logic parity(input logic [RES_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/mult_rr_arbiter_if.sv
// rtl/mult_rr_arbiter_if.sv - requester and multiplier-side signals of mult_rr_arbiter
interface mult_rr_arbiter_if #(
   parameter int N_REQ = 4
);
   import mult_arb_pkg::*;

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_a;
   logic [N_REQ*DATA_W-1:0] req_b;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ-1:0]        rsp_valid;
   logic [RES_W-1:0]        rsp_data;
   logic                    rsp_in_perr;
   logic                    rsp_out_perr;
   logic                    rsp_timeout;
   logic [DATA_W-1:0]       m_data_in;
   logic                    m_data_in_parity;
   logic                    m_data_in_valid;
   logic                    m_busy;
   logic [RES_W-1:0]        m_data_out;
   logic                    m_data_out_parity;
   logic                    m_data_out_valid;
   logic                    m_parity_error;

   // Arbiter view: owns grants, responses and the multiplier input stream
   modport master (
      input  req_valid, req_a, req_b,
      input  m_busy, m_data_out, m_data_out_parity, m_data_out_valid, m_parity_error,
      output req_ready, rsp_valid, rsp_data, rsp_in_perr, rsp_out_perr, rsp_timeout,
      output m_data_in, m_data_in_parity, m_data_in_valid
   );

   // Environment view: requesters plus the multiplier
   modport slave (
      output req_valid, req_a, req_b,
      output m_busy, m_data_out, m_data_out_parity, m_data_out_valid, m_parity_error,
      input  req_ready, rsp_valid, rsp_data, rsp_in_perr, rsp_out_perr, rsp_timeout,
      input  m_data_in, m_data_in_parity, m_data_in_valid
   );

endinterface

// File: rtl/mult_rr_pick.sv
// rtl/mult_rr_pick.sv - combinational round-robin picker: first request at or after ptr
module mult_rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         gnt,
   output logic [$clog2(N_REQ)-1:0] idx
);
   localparam int IDX_W = $clog2(N_REQ);

   // Scan slots ptr, ptr+1, ... wrapping, and keep the first one requesting
   always_comb begin
      int   slot;
      logic found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      slot  = 0;
      for (int k = 0; k < N_REQ; k++) begin
         slot = (int'(ptr) + k) % N_REQ;
         if (!found && req[slot]) begin
            found     = 1'b1;
            gnt[slot] = 1'b1;
            idx       = IDX_W'(slot);
         end
      end
   end

endmodule

// File: rtl/mult_rr_arbiter.sv
// rtl/mult_rr_arbiter.sv - round-robin sharing of one serial 16x16 multiplier; MULT_ARB_TIMEOUT_EN adds a WAIT watchdog
module mult_rr_arbiter
   import mult_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64
) (
   input logic               clk,
   input logic               rst,
   mult_rr_arbiter_if.master bus
);
   localparam int IDX_W = $clog2(N_REQ);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [DATA_W-1:0]   m_data_in_q, m_data_in_d;
   logic                m_data_in_parity_q, m_data_in_parity_d;
   logic                m_data_in_valid_q, m_data_in_valid_d;
   logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
   logic [RES_W-1:0]    rsp_data_q, rsp_data_d;
   logic                rsp_in_perr_q, rsp_in_perr_d;
   logic                rsp_out_perr_q, rsp_out_perr_d;
   logic [N_REQ-1:0]    pick_gnt;
   logic [IDX_W-1:0]    pick_idx;
   logic                grant_en;
   logic [DATA_W-1:0]   sel_a;

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic                rsp_timeout_q, rsp_timeout_d;
`else
   // TIMEOUT only has meaning when the watchdog is built
   logic [31:0]         unused_timeout;
   assign unused_timeout = TIMEOUT;
`endif

   mult_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req (bus.req_valid),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   assign sel_a = bus.req_a[int'(pick_idx)*DATA_W +: DATA_W];

   // Next state, operand capture, response capture and next registered outputs
   always_comb begin
      state_d            = state_q;
      ptr_d              = ptr_q;
      owner_d            = owner_q;
      a_d                = a_q;
      b_d                = b_q;
      rsp_data_d         = rsp_data_q;
      rsp_in_perr_d      = rsp_in_perr_q;
      rsp_out_perr_d     = rsp_out_perr_q;
      m_data_in_d        = '0;
      m_data_in_parity_d = 1'b0;
      m_data_in_valid_d  = 1'b0;
      rsp_valid_d        = '0;
      grant_en           = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
      wait_cnt_d         = wait_cnt_q;
      rsp_timeout_d      = rsp_timeout_q;
`endif
      case (state_q)
         IDLE: begin
            if (!rst && (|bus.req_valid) && !bus.m_busy) begin
               grant_en           = 1'b1;
               owner_d            = pick_idx;
               a_d                = sel_a;
               b_d                = bus.req_b[int'(pick_idx)*DATA_W +: DATA_W];
               ptr_d              = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
               m_data_in_d        = sel_a;
               m_data_in_parity_d = parity(RES_W'(sel_a));
               m_data_in_valid_d  = 1'b1;
               state_d            = SEND_A;
            end
         end
         SEND_A: state_d = GAP;
         GAP: begin
            m_data_in_d        = b_q;
            m_data_in_parity_d = parity(RES_W'(b_q));
            m_data_in_valid_d  = 1'b1;
            state_d            = SEND_B;
         end
         SEND_B: begin
`ifdef MULT_ARB_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.m_data_out_valid) begin
               rsp_data_d           = bus.m_data_out;
               rsp_in_perr_d        = bus.m_parity_error;
               rsp_out_perr_d       = bus.m_data_out_parity != parity(bus.m_data_out);
               rsp_valid_d[owner_q] = 1'b1;
               state_d              = RESP;
`ifdef MULT_ARB_TIMEOUT_EN
               rsp_timeout_d        = 1'b0;
            end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
               rsp_data_d           = '0;
               rsp_in_perr_d        = 1'b0;
               rsp_out_perr_d       = 1'b0;
               rsp_timeout_d        = 1'b1;
               rsp_valid_d[owner_q] = 1'b1;
               state_d              = RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
`endif
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM and all registered state; reset drops any in-flight transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q            <= IDLE;
         ptr_q              <= '0;
         owner_q            <= '0;
         a_q                <= '0;
         b_q                <= '0;
         m_data_in_q        <= '0;
         m_data_in_parity_q <= 1'b0;
         m_data_in_valid_q  <= 1'b0;
         rsp_valid_q        <= '0;
         rsp_data_q         <= '0;
         rsp_in_perr_q      <= 1'b0;
         rsp_out_perr_q     <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
         wait_cnt_q         <= '0;
         rsp_timeout_q      <= 1'b0;
`endif
      end else begin
         state_q            <= state_d;
         ptr_q              <= ptr_d;
         owner_q            <= owner_d;
         a_q                <= a_d;
         b_q                <= b_d;
         m_data_in_q        <= m_data_in_d;
         m_data_in_parity_q <= m_data_in_parity_d;
         m_data_in_valid_q  <= m_data_in_valid_d;
         rsp_valid_q        <= rsp_valid_d;
         rsp_data_q         <= rsp_data_d;
         rsp_in_perr_q      <= rsp_in_perr_d;
         rsp_out_perr_q     <= rsp_out_perr_d;
`ifdef MULT_ARB_TIMEOUT_EN
         wait_cnt_q         <= wait_cnt_d;
         rsp_timeout_q      <= rsp_timeout_d;
`endif
      end
   end

   assign bus.req_ready        = grant_en ? pick_gnt : '0;
   assign bus.rsp_valid        = rsp_valid_q;
   assign bus.rsp_data         = rsp_data_q;
   assign bus.rsp_in_perr      = rsp_in_perr_q;
   assign bus.rsp_out_perr     = rsp_out_perr_q;
   assign bus.m_data_in        = m_data_in_q;
   assign bus.m_data_in_parity = m_data_in_parity_q;
   assign bus.m_data_in_valid  = m_data_in_valid_q;
`ifdef MULT_ARB_TIMEOUT_EN
   assign bus.rsp_timeout      = rsp_timeout_q;
`else
   assign bus.rsp_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// tb/tb_mult_rr_arbiter.sv - randomized self-checking bench for mult_rr_arbiter
module tb_mult_rr_arbiter;
   localparam int N   = 4;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mult_rr_arbiter_if #(.N_REQ(N)) bus ();

   mult_rr_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [N-1:0] rv;
   logic [15:0] ra [N];
   logic [15:0] rb [N];
   int          m_ptr;
   int          grants [$];
   logic [31:0] last_data;
   logic [2:0]  last_flags;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic apply();
      bus.req_valid = rv;
      for (int i = 0; i < N; i++) begin
         bus.req_a[i*16 +: 16] = ra[i];
         bus.req_b[i*16 +: 16] = rb[i];
      end
   endtask

   function automatic logic [31:0] mul16(input logic [15:0] x, input logic [15:0] y);
      logic signed [31:0] sx, sy;
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
   endfunction

   // Round-robin rule: first requester at or after the pointer, wrapping
   function automatic int rr_winner();
      for (int k = 0; k < N; k++)
         if (rv[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   function automatic logic [63:0] all_outs();
      return 64'({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_in_perr, bus.rsp_out_perr,
                  bus.rsp_timeout, bus.m_data_in, bus.m_data_in_parity, bus.m_data_in_valid});
   endfunction

   // One full transaction starting in IDLE; lat < 0 means the multiplier never answers
   task automatic serve(input int lat, input bit perr_in, input bit bad_par, input bit zero_prod,
                        input bit busy_first);
      int          w;
      logic [15:0] a, b, oa, ob;
      logic [31:0] prod, exp;
      logic [2:0]  exp_flags;
      if (busy_first) begin
         bus.m_busy = 1'b1;
         apply();
         #1;
         check("busy_no_grant", 64'(bus.req_ready), 64'd0);
         cyc();
         bus.m_busy = 1'b0;
      end
      apply();
      #1;
      w = rr_winner();
      if (w < 0) begin
         check("idle_no_grant", 64'(bus.req_ready), 64'd0);
         cyc();
         return;
      end
      check("grant", 64'(bus.req_ready), 64'(1 << w));
      a = ra[w];
      b = rb[w];
      grants.push_back(w);
      m_ptr = (w + 1) % N;
      cyc();
      check("a_word", 64'({bus.m_data_in_valid, bus.m_data_in_parity, bus.m_data_in}), 64'({1'b1, ^a, a}));
      oa = bus.m_data_in;
      cyc();
      check("gap_word", 64'({bus.m_data_in_valid, bus.m_data_in_parity, bus.m_data_in}), 64'd0);
      bus.m_data_out_valid = 1'b1;
      bus.m_parity_error   = 1'b1;
      bus.m_data_out       = $urandom;
      cyc();
      bus.m_data_out_valid = 1'b0;
      bus.m_parity_error   = 1'b0;
      check("b_word", 64'({bus.m_data_in_valid, bus.m_data_in_parity, bus.m_data_in}), 64'({1'b1, ^b, b}));
      ob = bus.m_data_in;
      cyc();
      check("wait_quiet", 64'({bus.m_data_in_valid, bus.m_data_in_parity, bus.m_data_in, bus.rsp_valid}), 64'd0);
      check("rsp_hold", 64'({bus.rsp_data, bus.rsp_in_perr, bus.rsp_out_perr, bus.rsp_timeout}),
            64'({last_data, last_flags}));
      exp       = '0;
      exp_flags = 3'b000;
`ifdef MULT_ARB_TIMEOUT_EN
      if (lat < 0) begin
         for (int k = 1; k < TMO; k++) begin
            cyc();
            check("tmo_quiet", 64'(bus.rsp_valid), 64'd0);
         end
         exp       = '0;
         exp_flags = 3'b001;
      end else
`endif
      begin
         repeat (lat) cyc();
         prod                  = zero_prod ? 32'd0 : mul16(oa, ob);
         bus.m_data_out        = prod;
         bus.m_data_out_parity = (^prod) ^ bad_par;
         bus.m_parity_error    = perr_in;
         bus.m_data_out_valid  = 1'b1;
         exp                   = zero_prod ? 32'd0 : mul16(a, b);
         exp_flags             = {perr_in, bad_par, 1'b0};
      end
      cyc();
      bus.m_data_out_valid = 1'b0;
      bus.m_parity_error   = 1'b0;
      bus.m_data_out       = $urandom;
      apply();
      #1;
      check("rsp_valid", 64'(bus.rsp_valid), 64'(1 << w));
      check("rsp_data", 64'(bus.rsp_data), 64'(exp));
      check("rsp_flags", 64'({bus.rsp_in_perr, bus.rsp_out_perr, bus.rsp_timeout}), 64'(exp_flags));
      check("resp_no_grant", 64'(bus.req_ready), 64'd0);
      last_data  = exp;
      last_flags = exp_flags;
      cyc();
      check("rsp_pulse", 64'(bus.rsp_valid), 64'd0);
   endtask

   initial begin
      int exp_order [5] = '{0, 1, 2, 3, 0};
      rst                   = 1'b1;
      rv                    = '1;
      bus.m_busy            = 1'b0;
      bus.m_data_out        = '0;
      bus.m_data_out_parity = 1'b0;
      bus.m_data_out_valid  = 1'b0;
      bus.m_parity_error    = 1'b0;
      for (int i = 0; i < N; i++) begin
         ra[i] = 16'(16'h1111 * (i + 1));
         rb[i] = 16'(16'hF00D - 16'(i * 3));
      end
      apply();
      m_ptr      = 0;
      last_data  = '0;
      last_flags = '0;
      repeat (3) cyc();
      check("reset_outs", all_outs(), 64'd0);
      rst = 1'b0;

      // All requesters held valid: strict rotation
      for (int i = 0; i < 5; i++) serve(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) check("rr_order", 64'(grants[i]), 64'(exp_order[i]));

      // Extreme operands on requester 0
      rv = 4'b0001; ra[0] = 16'h7FFF; rb[0] = 16'h8000;
      serve(2, 0, 0, 0, 0);
      check("max_prod", 64'(bus.rsp_data), 64'h0000_0000_C000_8000);

      // Operand parity error reported, then cleared by a clean transaction
      rv = 4'b0010;
      serve(1, 1, 0, 1, 0);
      serve(0, 0, 0, 0, 1);

      // Corrupted result parity on product 1
      rv = 4'b0001; ra[0] = 16'h0001; rb[0] = 16'h0001;
      serve(0, 0, 1, 0, 0);
      check("one_prod", 64'(bus.rsp_data), 64'd1);

      // Reset in WAIT drops the transaction and returns the pointer to 0
      rv = 4'b0100;
      apply();
      #1;
      check("pre_rst_grant", 64'(bus.req_ready), 64'b0100);
      repeat (4) cyc();
      rst = 1'b1;
      rv  = 4'b1100;
      apply();
      bus.m_data_out_valid = 1'b1;
      cyc();
      bus.m_data_out_valid = 1'b0;
      check("rst_outs", all_outs(), 64'd0);
      rst        = 1'b0;
      m_ptr      = 0;
      last_data  = '0;
      last_flags = '0;
      serve(1, 0, 0, 0, 0);

`ifdef MULT_ARB_TIMEOUT_EN
      rv = 4'b1000;
      serve(-1, 0, 0, 0, 0);
      serve(1, 0, 0, 0, 0);
`endif

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         rv = 4'($urandom_range(1, 15));
         for (int i = 0; i < N; i++) begin
            ra[i] = 16'($urandom);
            rb[i] = 16'($urandom);
         end
         serve(int'($urandom_range(0, 4)), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
